chrono_bcd: RTL and testbench
=============================

# chrono_bcd

Stopwatch counter that consumes the one-per-second waveform produced by the frequency divider and counts elapsed time as four BCD digits, MM:SS, from 00:00 to 59:59. It runs in the same clock domain as the divider, `clkIn`. It treats the divider output purely as data: it detects the period-start edge and never uses the waveform as a clock. Its outputs drive the 7-segment display decoder stage.

## Interface
Parameters:
- `TICK_POL`, default 0 — polarity of the divider output. 0: each period starts on a rising edge of `tickIn`. 1: each period starts on a falling edge.

Ports:
- `clkIn`  in  1  system clock (50 MHz); all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `tickIn`  in  1  divider output; one count per period-start edge
- `btnStartStop`  in  1  level input; its rising edge is a start/stop command
- `btnClear`  in  1  level input; its rising edge is a clear command
- `btnLap`  in  1  level input; its rising edge is a lap command (used only with `CHRONO_LAP_EN`)
- `secU`  out  4  seconds units, BCD 0–9
- `secT`  out  4  seconds tens, BCD 0–5
- `minU`  out  4  minutes units, BCD 0–9
- `minT`  out  4  minutes tens, BCD 0–5
- `running`  out  1  high while in state RUN
- `frozen`  out  1  high while the display is lap-frozen
- `ovf`  out  1  one-cycle pulse on wrap 59:59 → 00:00

## Operation
- **Reset:**
  - All digits 0, state IDLE, `running`=0, `frozen`=0, `ovf`=0.
  - Edge-detect history registers reset: button history to 0, tick history to `TICK_POL`.
- **Input sampling:** each input is registered once (`xR`), then delayed once (`xP`).
  - Tick event: `tickR != TICK_POL && tickP == TICK_POL`.
  - Button event: `btnR && !btnP`.
- **States:** IDLE, RUN, PAUSE.
  - Start/stop event: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
  - Clear event from any state: → IDLE, all digits 0, `frozen`=0.
  - Clear has priority over start/stop and lap in the same cycle.
- **Counting:**
  - A tick event increments only when the current state is RUN.
  - The state in effect before the clock edge decides. A tick coincident with the stop event is counted; a tick coincident with the start event from IDLE or PAUSE is not.
- **Cascade:**
  - `secU` 9→0 carries into `secT`; `secT` 5→0 carries into `minU`; `minU` 9→0 carries into `minT`.
  - `minT` 5→0 wraps the whole counter to 00:00 and asserts `ovf` for one cycle.
  - Digits never hold non-BCD values.
- Tick events in IDLE and PAUSE are discarded, not queued.

## Timing
- Latency from an input level change (`tickIn` edge or button edge) to the registered output change is 2 `clkIn` cycles: input register, then state/counter register.
- All outputs are registered; no combinational path from input to output.
- Input pulses shorter than 1 `clkIn` period may be missed.
- Minimum spacing between two detected events of the same input is 2 cycles.
- Asynchronous `rst` assertion mid-count clears everything immediately; counting resumes only after a start/stop event following deassertion.

## Configuration
- `CHRONO_LAP_EN` defined:
  - A lap event in RUN or PAUSE toggles `frozen`.
  - While `frozen`=1, the outputs `secU`/`secT`/`minU`/`minT` hold the snapshot taken at the freezing event, and the internal count keeps advancing.
  - Unfreezing presents the live count on the next cycle.
  - Lap in IDLE is ignored.
- `CHRONO_LAP_EN` undefined:
  - `btnLap` is ignored and `frozen` is tied to 0.
  - The outputs always show the live count; no snapshot registers.

## Structure
- Package `chrono_pkg`: state encoding (IDLE/RUN/PAUSE), constants `BCD_UNITS_MAX`=9 and `BCD_TENS_MAX`=5, digit width 4.
- Sub-module `bcd_digit`, instantiated 4 times:
  - Ports: clock, reset, `inc`, `clr`, `MAX` parameter, 4-bit value out, carry out.
  - Carry is combinational: `inc && value==MAX`.

## Test plan
- Reset, then start, then 3 tick edges (bench divider NBT=10) → display 00:03, `running`=1.
- Preload 00:59 via 59 ticks, then 1 tick → display 01:00, digits cascade in the same cycle.
- Run to 59:59, then 1 tick → display 00:00, `ovf` high for exactly 1 cycle.
- Stop asserted in the same cycle as a tick event → count incremented, state PAUSE; further ticks leave the count unchanged.
- Clear and start/stop asserted in the same cycle during RUN at 00:07 → display 00:00, state IDLE.
- With `CHRONO_LAP_EN`: lap at 00:05, 4 more ticks → display 00:05; lap again → display 00:09.

Source files
------------

// File: rtl/chrono_bcd_pkg.sv
// Shared types and constants for the MM:SS stopwatch: state encoding and BCD digit limits.
package chrono_pkg;
  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t BCD_UNITS_MAX = 4'd9;
  localparam digit_t BCD_TENS_MAX  = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;
endpackage

// File: rtl/chrono_bcd_if.sv
// Stopwatch control inputs and display outputs; the stopwatch sits on the slave side.
interface chrono_bcd_if;
  import chrono_pkg::*;

  logic   tickIn;
  logic   btnStartStop;
  logic   btnClear;
  logic   btnLap;
  digit_t secU;
  digit_t secT;
  digit_t minU;
  digit_t minT;
  logic   running;
  logic   frozen;
  logic   ovf;

  modport master (
    output tickIn, btnStartStop, btnClear, btnLap,
    input  secU, secT, minU, minT, running, frozen, ovf
  );

  modport slave (
    input  tickIn, btnStartStop, btnClear, btnLap,
    output secU, secT, minU, minT, running, frozen, ovf
  );
endinterface

// File: rtl/chrono_bcd_digit.sv
// One BCD counter digit that rolls over after MAX; carry is combinational so a cascade settles in one cycle.
module bcd_digit
  import chrono_pkg::*;
#(
  parameter digit_t MAX = BCD_UNITS_MAX
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   inc,
  input  logic   clr,
  output digit_t value,
  output logic   carry
);

  digit_t value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      // >= keeps the digit inside its range even from an unexpected value
      value_d = (value_q >= MAX) ? '0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;
  assign carry = inc && (value_q == MAX);

endmodule

// File: rtl/chrono_bcd.sv
// MM:SS stopwatch driven by the divider's tick waveform (sampled as data, never as a clock).
// Optional lap-freeze display enabled by defining CHRONO_LAP_EN.
module chrono_bcd
  import chrono_pkg::*;
#(
  parameter logic TICK_POL = 1'b0
) (
  input logic         clkIn,
  input logic         rst,
  chrono_bcd_if.slave bus
);

  logic   tick_r_q, tick_p_q;
  logic   ss_r_q, ss_p_q;
  logic   clr_r_q, clr_p_q;
  state_t state_q, state_d;
  logic   running_q, running_d;
  logic   ovf_q, ovf_d;
  logic   tick_ev, ss_ev, clr_ev, count_inc;
  logic   c_su, c_st, c_mu, c_mt;
  digit_t su, st, mu, mt;

  assign tick_ev   = (tick_r_q != TICK_POL) && (tick_p_q == TICK_POL);
  assign ss_ev     = ss_r_q && !ss_p_q;
  assign clr_ev    = clr_r_q && !clr_p_q;
  // The pre-edge state gates counting, so a tick coincident with stop still counts
  assign count_inc = tick_ev && (state_q == RUN) && !clr_ev;

  always_comb begin
    state_d = state_q;
    if (clr_ev) begin
      state_d = IDLE;
    end else if (ss_ev) begin
      case (state_q)
        RUN:     state_d = PAUSE;
        default: state_d = RUN;
      endcase
    end
    running_d = (state_d == RUN);
    ovf_d     = c_mt;
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      tick_r_q  <= TICK_POL;
      tick_p_q  <= TICK_POL;
      ss_r_q    <= 1'b0;
      ss_p_q    <= 1'b0;
      clr_r_q   <= 1'b0;
      clr_p_q   <= 1'b0;
      state_q   <= IDLE;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      tick_r_q  <= bus.tickIn;
      tick_p_q  <= tick_r_q;
      ss_r_q    <= bus.btnStartStop;
      ss_p_q    <= ss_r_q;
      clr_r_q   <= bus.btnClear;
      clr_p_q   <= clr_r_q;
      state_q   <= state_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
    end
  end

  bcd_digit #(.MAX(BCD_UNITS_MAX)) u_sec_u (
    .clk(clkIn), .rst(rst), .inc(count_inc), .clr(clr_ev), .value(su), .carry(c_su)
  );
  bcd_digit #(.MAX(BCD_TENS_MAX)) u_sec_t (
    .clk(clkIn), .rst(rst), .inc(c_su), .clr(clr_ev), .value(st), .carry(c_st)
  );
  bcd_digit #(.MAX(BCD_UNITS_MAX)) u_min_u (
    .clk(clkIn), .rst(rst), .inc(c_st), .clr(clr_ev), .value(mu), .carry(c_mu)
  );
  bcd_digit #(.MAX(BCD_TENS_MAX)) u_min_t (
    .clk(clkIn), .rst(rst), .inc(c_mu), .clr(clr_ev), .value(mt), .carry(c_mt)
  );

  assign bus.running = running_q;
  assign bus.ovf     = ovf_q;

`ifdef CHRONO_LAP_EN
  logic        lap_r_q, lap_p_q, lap_ev;
  logic        frozen_q, frozen_d;
  logic [15:0] snap_q, snap_d;

  assign lap_ev = lap_r_q && !lap_p_q;

  always_comb begin
    frozen_d = frozen_q;
    snap_d   = snap_q;
    if (clr_ev) begin
      frozen_d = 1'b0;
    end else if (lap_ev && (state_q != IDLE)) begin
      frozen_d = !frozen_q;
      if (!frozen_q) snap_d = {mt, mu, st, su};
    end
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      lap_r_q  <= 1'b0;
      lap_p_q  <= 1'b0;
      frozen_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      lap_r_q  <= bus.btnLap;
      lap_p_q  <= lap_r_q;
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
    end
  end

  assign bus.frozen = frozen_q;
  assign {bus.minT, bus.minU, bus.secT, bus.secU} = frozen_q ? snap_q : {mt, mu, st, su};
`else
  logic lap_unused;
  assign lap_unused = bus.btnLap;
  assign bus.frozen = 1'b0;
  assign {bus.minT, bus.minU, bus.secT, bus.secU} = {mt, mu, st, su};
`endif

endmodule

// File: tb/tb_chrono_bcd.sv
// Self-checking bench for chrono_bcd: directed table, corner sequences, then random ops against an elapsed-seconds model.
module tb_chrono_bcd;
  import chrono_pkg::*;

  localparam logic TP = 1'b0;
`ifdef CHRONO_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  localparam int OP_NONE = 0;
  localparam int OP_TICK = 1;
  localparam int OP_SS   = 2;
  localparam int OP_CLR  = 3;
  localparam int OP_LAP  = 4;

  typedef struct {
    int   op;
    int   n;
    int   exp_sec;
    logic exp_run;
    logic exp_frz;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  chrono_bcd_if bus();

  chrono_bcd #(.TICK_POL(TP)) dut (
    .clkIn(clk),
    .rst  (rst),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;

  always @(posedge clk) begin
    #1;
    if (bus.ovf === 1'b1) ovf_seen++;
  end

  // Reference model: elapsed seconds plus run state and lap snapshot
  int m_total, m_state, m_snap, m_wraps;
  bit m_frozen;

  function automatic logic [15:0] bcd_of(int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] disp();
    return {bus.minT, bus.minU, bus.secT, bus.secU};
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_state(string name, int exp_sec, logic exp_run, logic exp_frz);
    chk({name, "_disp"}, disp(), bcd_of(exp_sec));
    chk({name, "_running"}, 16'(bus.running), 16'(exp_run));
    chk({name, "_frozen"}, 16'(bus.frozen), 16'(exp_frz));
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int which);
    case (which)
      OP_SS:   bus.btnStartStop = 1'b1;
      OP_CLR:  bus.btnClear = 1'b1;
      default: bus.btnLap = 1'b1;
    endcase
    cyc(3);
    bus.btnStartStop = 1'b0;
    bus.btnClear = 1'b0;
    bus.btnLap = 1'b0;
    cyc(3);
  endtask

  task automatic tick_n(int n, int half);
    repeat (n) begin
      bus.tickIn = ~TP;
      cyc(half);
      bus.tickIn = TP;
      cyc(half);
    end
    cyc(2);
  endtask

  task automatic coincident_tick_ss();
    bus.tickIn = ~TP;
    bus.btnStartStop = 1'b1;
    cyc(3);
    bus.tickIn = TP;
    bus.btnStartStop = 1'b0;
    cyc(3);
  endtask

  // Drive one tick edge and stop at the first cycle where the display moves
  task automatic tick_watch(int from_sec);
    bus.tickIn = ~TP;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (disp() !== bcd_of(from_sec)) break;
    end
  endtask

  task automatic model_op(int op);
    case (op)
      OP_TICK: if (m_state == 1) begin
        m_total++;
        if (m_total == 3600) begin
          m_total = 0;
          m_wraps++;
        end
      end
      OP_SS:  m_state = (m_state == 1) ? 2 : 1;
      OP_CLR: begin
        m_state = 0;
        m_total = 0;
        m_frozen = 1'b0;
      end
      OP_LAP: if (LAP && m_state != 0) begin
        if (!m_frozen) m_snap = m_total;
        m_frozen = !m_frozen;
      end
      default: ;
    endcase
  endtask

  vec_t tbl[11];
  int base;

  initial begin
    tbl[0]  = '{OP_NONE, 0,  0,  1'b0, 1'b0};
    tbl[1]  = '{OP_SS,   0,  0,  1'b1, 1'b0};
    tbl[2]  = '{OP_TICK, 3,  3,  1'b1, 1'b0};
    tbl[3]  = '{OP_TICK, 56, 59, 1'b1, 1'b0};
    tbl[4]  = '{OP_TICK, 1,  60, 1'b1, 1'b0};
    tbl[5]  = '{OP_SS,   0,  60, 1'b0, 1'b0};
    tbl[6]  = '{OP_TICK, 5,  60, 1'b0, 1'b0};
    tbl[7]  = '{OP_SS,   0,  60, 1'b1, 1'b0};
    tbl[8]  = '{OP_CLR,  0,  0,  1'b0, 1'b0};
    tbl[9]  = '{OP_SS,   0,  0,  1'b1, 1'b0};
    tbl[10] = '{OP_TICK, 7,  7,  1'b1, 1'b0};

    rst = 1'b1;
    bus.tickIn = TP;
    bus.btnStartStop = 1'b0;
    bus.btnClear = 1'b0;
    bus.btnLap = 1'b0;
    cyc(3);
    chk("reset_ovf", 16'(bus.ovf), 16'd0);
    rst = 1'b0;
    cyc(2);

    for (int i = 0; i < 11; i++) begin
      base = ovf_seen;
      case (tbl[i].op)
        OP_TICK: tick_n(tbl[i].n, 2);
        OP_NONE: cyc(1);
        default: press(tbl[i].op);
      endcase
      check_state($sformatf("tbl%0d", i), tbl[i].exp_sec, tbl[i].exp_run, tbl[i].exp_frz);
      chk($sformatf("tbl%0d_ovf", i), 16'(ovf_seen - base), 16'd0);
    end

    // Clear wins over a simultaneous start/stop while running at 00:07
    bus.btnClear = 1'b1;
    bus.btnStartStop = 1'b1;
    cyc(3);
    bus.btnClear = 1'b0;
    bus.btnStartStop = 1'b0;
    cyc(3);
    check_state("clr_ss", 0, 1'b0, 1'b0);

    // Tick coincident with stop counts; tick coincident with restart does not
    press(OP_SS);
    tick_n(4, 2);
    coincident_tick_ss();
    check_state("stop_tick", 5, 1'b0, 1'b0);
    tick_n(3, 3);
    check_state("pause_ticks", 5, 1'b0, 1'b0);
    coincident_tick_ss();
    check_state("start_tick", 5, 1'b1, 1'b0);
    tick_n(1, 2);
    check_state("resume", 6, 1'b1, 1'b0);

    // 00:59 -> 01:00 with all digits moving in the same cycle
    press(OP_CLR);
    press(OP_SS);
    tick_n(59, 2);
    check_state("pre_cascade", 59, 1'b1, 1'b0);
    tick_watch(59);
    chk("cascade", disp(), bcd_of(60));
    bus.tickIn = TP;
    cyc(3);

    // 59:59 -> 00:00 with a single-cycle ovf pulse
    tick_n(3539, 2);
    check_state("pre_wrap", 3599, 1'b1, 1'b0);
    base = ovf_seen;
    tick_watch(3599);
    chk("wrap_disp", disp(), bcd_of(0));
    chk("wrap_ovf_level", 16'(bus.ovf), 16'd1);
    bus.tickIn = TP;
    cyc(4);
    chk("wrap_ovf_pulses", 16'(ovf_seen - base), 16'd1);
    check_state("post_wrap", 0, 1'b1, 1'b0);

    // Asynchronous reset mid-count
    tick_n(5, 2);
    check_state("pre_rst", 5, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_disp", disp(), bcd_of(0));
    chk("async_rst_run", 16'(bus.running), 16'd0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    tick_n(3, 2);
    check_state("rst_idle_ticks", 0, 1'b0, 1'b0);
    press(OP_SS);
    tick_n(2, 2);
    check_state("rst_restart", 2, 1'b1, 1'b0);

    // Lap freeze / unfreeze (ignored when the feature is built out)
    press(OP_CLR);
    press(OP_LAP);
    check_state("lap_idle", 0, 1'b0, 1'b0);
    press(OP_SS);
    tick_n(5, 2);
    press(OP_LAP);
    check_state("lap_freeze", 5, 1'b1, LAP);
    tick_n(4, 2);
    check_state("lap_hold", LAP ? 5 : 9, 1'b1, LAP);
    press(OP_LAP);
    check_state("lap_release", 9, 1'b1, 1'b0);

    // Random operations against the model
    press(OP_CLR);
    m_total = 0; m_state = 0; m_snap = 0; m_frozen = 1'b0; m_wraps = 0;
    for (int k = 0; k < 400; k++) begin
      int r, op;
      r = $urandom_range(0, 19);
      op = (r < 12) ? OP_TICK : (r < 16) ? OP_SS : (r < 17) ? OP_CLR : OP_LAP;
      base = ovf_seen;
      m_wraps = 0;
      if (op == OP_TICK) tick_n(1, $urandom_range(2, 4));
      else press(op);
      model_op(op);
      check_state($sformatf("rnd%0d", k), m_frozen ? m_snap : m_total, m_state == 1, m_frozen);
      chk($sformatf("rnd%0d_ovf", k), 16'(ovf_seen - base), 16'(m_wraps));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
